// File: rtl/matrix_cmd_decoder.sv
// -----------------------------------------------------------------------------
// matrix_cmd_decoder
//   Front-end of the matrix execution unit. Accepts 32-bit matrix instruction
//   words, decodes them into commands (op, register indices, address) and
//   queues them in a small registered FIFO for the executor. Illegal words are
//   consumed, dropped and counted.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   flush             empties the command queue (illegal count is kept)
//   instr_valid/ready instruction stream in, instr_data = {op,rd,rs1,rs2,addr}
//   cmd_valid/ready   command stream out (head of the queue)
//   cmd_op/rd/rs1/rs2/addr  decoded head command (zero while queue empty)
//   queue_count       entries currently held
//   illegal_count     saturating count of dropped instructions
//   illegal_pulse     one-cycle pulse the cycle after a drop
// -----------------------------------------------------------------------------
module matrix_cmd_decoder #(
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_MREGS  = 8,
   parameter int ADDR_W     = 14
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          instr_valid,
   output logic                          instr_ready,
   input  logic [31:0]                   instr_data,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [2:0]                    cmd_op,
   output logic [4:0]                    cmd_rd,
   output logic [4:0]                    cmd_rs1,
   output logic [4:0]                    cmd_rs2,
   output logic [ADDR_W-1:0]             cmd_addr,
   output logic [$clog2(FIFO_DEPTH):0]   queue_count,
   output logic [7:0]                    illegal_count,
   output logic                          illegal_pulse
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [5:0] NREG = 6'(NUM_MREGS);

   typedef enum logic [2:0] {
      MATRIX_NONE      = 3'd0,
      MATRIX_LOAD      = 3'd1,
      MATRIX_STORE     = 3'd2,
      MATRIX_MULTIPLY  = 3'd3,
      MATRIX_ADD       = 3'd4,
      MATRIX_SUBTRACT  = 3'd5,
      MATRIX_TRANSPOSE = 3'd6,
      MATRIX_UNDEF     = 3'd7
   } matrix_op_t;

   typedef struct packed {
      matrix_op_t          op;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [ADDR_W-1:0]   addr;
   } cmd_t;

   // ---------------------------------------------------------------- decode
   matrix_op_t   w_op;
   logic [4:0]   w_rd, w_rs1, w_rs2;
   logic         w_rd_ok, w_rs1_ok, w_rs2_ok;
   logic         w_illegal;
   cmd_t         w_dec;

   assign w_op     = matrix_op_t'(instr_data[31:29]);
   assign w_rd     = instr_data[28:24];
   assign w_rs1    = instr_data[23:19];
   assign w_rs2    = instr_data[18:14];
   assign w_rd_ok  = {1'b0, w_rd}  < NREG;
   assign w_rs1_ok = {1'b0, w_rs1} < NREG;
   assign w_rs2_ok = {1'b0, w_rs2} < NREG;

   // Fields an op does not use are forced to zero so the executor never sees
   // stale register indices or addresses.
   always_comb begin
      w_dec     = '0;
      w_illegal = 1'b1;
      case (w_op)
         MATRIX_LOAD: begin
            w_dec.op   = MATRIX_LOAD;
            w_dec.rd   = w_rd;
            w_dec.addr = instr_data[ADDR_W-1:0];
            w_illegal  = !w_rd_ok;
         end
         MATRIX_STORE: begin
            w_dec.op   = MATRIX_STORE;
            w_dec.rs1  = w_rs1;
            w_dec.addr = instr_data[ADDR_W-1:0];
            w_illegal  = !w_rs1_ok;
         end
         MATRIX_MULTIPLY, MATRIX_ADD, MATRIX_SUBTRACT: begin
            w_dec.op   = w_op;
            w_dec.rd   = w_rd;
            w_dec.rs1  = w_rs1;
            w_dec.rs2  = w_rs2;
            w_illegal  = !(w_rd_ok && w_rs1_ok && w_rs2_ok);
         end
         MATRIX_TRANSPOSE: begin
            w_dec.op   = MATRIX_TRANSPOSE;
            w_dec.rd   = w_rd;
            w_dec.rs1  = w_rs1;
            w_illegal  = !(w_rd_ok && w_rs1_ok);
         end
         default: begin
            w_dec     = '0;
            w_illegal = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------- fifo
   cmd_t              r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr, r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic [7:0]        r_illegal_count;
   logic              r_illegal_pulse;

   logic  w_full, w_accept, w_push, w_pop;
   cmd_t  w_head;

   assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
   // Ready is a pure function of state and flush; no bypass when full.
   assign instr_ready = !w_full && !flush && !rst;
   assign w_accept    = instr_valid && instr_ready;
   assign w_push      = w_accept && !w_illegal;
   assign cmd_valid   = (r_count != '0);
   assign w_pop       = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr          <= '0;
         r_rptr          <= '0;
         r_count         <= '0;
         r_illegal_count <= '0;
         r_illegal_pulse <= 1'b0;
      end else begin
         r_illegal_pulse <= w_accept && w_illegal;
         if (w_accept && w_illegal && (r_illegal_count != 8'hFF))
            r_illegal_count <= r_illegal_count + 8'd1;

         // A pop in the flush cycle is acknowledged on the bus but the queue
         // is emptied regardless.
         if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
         end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         end
      end
   end

   // Storage needs no reset: contents are only visible while count != 0.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= w_dec;
   end

   assign w_head = r_mem[r_rptr];

   // Outputs read zero while empty so reset/flush leave every output at 0.
   assign cmd_op        = cmd_valid ? w_head.op   : MATRIX_NONE;
   assign cmd_rd        = cmd_valid ? w_head.rd   : '0;
   assign cmd_rs1       = cmd_valid ? w_head.rs1  : '0;
   assign cmd_rs2       = cmd_valid ? w_head.rs2  : '0;
   assign cmd_addr      = cmd_valid ? w_head.addr : '0;
   assign queue_count   = r_count;
   assign illegal_count = r_illegal_count;
   assign illegal_pulse = r_illegal_pulse;

endmodule

// File: tb/tb_matrix_cmd_decoder.sv
module tb_matrix_cmd_decoder;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [31:0] instr_data = '0;
   logic        cmd_valid;
   logic        cmd_ready = 1'b0;
   logic [2:0]  cmd_op;
   logic [4:0]  cmd_rd, cmd_rs1, cmd_rs2;
   logic [13:0] cmd_addr;
   logic [2:0]  queue_count;
   logic [7:0]  illegal_count;
   logic        illegal_pulse;

   matrix_cmd_decoder #(.FIFO_DEPTH(DEPTH), .NUM_MREGS(8), .ADDR_W(14)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
      .cmd_addr(cmd_addr), .queue_count(queue_count),
      .illegal_count(illegal_count), .illegal_pulse(illegal_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      int op, rd, rs1, rs2, addr;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   m_ill = 0;
   bit   m_pulse = 0;
   bit   mon_popped = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
      end
   endtask

   // Reference decode straight from the ISA rules: which fields each op uses.
   function automatic void model(input logic [31:0] w, output bit legal, output exp_t e);
      int op, rd, rs1, rs2;
      bit u_rd, u_rs1, u_rs2, u_addr;
      op  = int'(w[31:29]);
      rd  = int'(w[28:24]);
      rs1 = int'(w[23:19]);
      rs2 = int'(w[18:14]);
      u_rd   = op inside {1, 3, 4, 5, 6};
      u_rs1  = op inside {2, 3, 4, 5, 6};
      u_rs2  = op inside {3, 4, 5};
      u_addr = op inside {1, 2};
      legal  = (op != 0) && (op != 7) && !(u_rd && rd >= 8) &&
               !(u_rs1 && rs1 >= 8) && !(u_rs2 && rs2 >= 8);
      e.op   = op;
      e.rd   = u_rd   ? rd  : 0;
      e.rs1  = u_rs1  ? rs1 : 0;
      e.rs2  = u_rs2  ? rs2 : 0;
      e.addr = u_addr ? int'(w[13:0]) : 0;
   endfunction

   function automatic logic [31:0] mk(input int op, input int rd, input int rs1,
                                       input int rs2, input int addr);
      logic [31:0] w;
      w = {3'(op), 5'(rd), 5'(rs1), 5'(rs2), 14'(addr)};
      return w;
   endfunction

   function automatic logic [31:0] rnd_word();
      int r[3];
      for (int i = 0; i < 3; i++)
         r[i] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 31)) : int'($urandom_range(0, 7));
      return mk(int'($urandom_range(0, 7)), r[0], r[1], r[2], int'($urandom_range(0, 16383)));
   endfunction

   // Monitor: pops and compares every output transfer.
   initial begin
      forever begin
         @(negedge clk);
         mon_popped = 0;
         if (!rst && !flush && cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_cmd", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               mon_popped = 1;
               chk("cmd_op",   int'(cmd_op),   e.op);
               chk("cmd_rd",   int'(cmd_rd),   e.rd);
               chk("cmd_rs1",  int'(cmd_rs1),  e.rs1);
               chk("cmd_rs2",  int'(cmd_rs2),  e.rs2);
               chk("cmd_addr", int'(cmd_addr), e.addr);
            end
         end
      end
   end

   // One cycle of stimulus plus status checks; model updated for this edge.
   task automatic step(input bit v, input logic [31:0] d, input bit rdy, input bit fl,
                       output bit acc);
      int   held;
      bit   legal;
      exp_t e;
      @(posedge clk); #1;
      instr_valid = v; instr_data = d; cmd_ready = rdy; flush = fl;
      @(negedge clk); #1;
      held = exp_q.size() + int'(mon_popped);
      chk("queue_count",   int'(queue_count),   held);
      chk("cmd_valid",     int'(cmd_valid),     int'(held != 0));
      chk("instr_ready",   int'(instr_ready),   int'(!fl && held != DEPTH));
      chk("illegal_count", int'(illegal_count), m_ill);
      chk("illegal_pulse", int'(illegal_pulse), int'(m_pulse));
      acc = v && instr_ready;
      m_pulse = 0;
      if (fl) exp_q.delete();
      else if (acc) begin
         model(d, legal, e);
         if (legal) exp_q.push_back(e);
         else begin
            m_pulse = 1;
            if (m_ill < 255) m_ill++;
         end
      end
   endtask

   task automatic idle(input int n, input bit rdy);
      bit a;
      for (int i = 0; i < n; i++) step(0, 32'h0, rdy, 0, a);
   endtask

   // Push one word, retrying while backpressured (bounded).
   task automatic push(input logic [31:0] d, input bit rdy);
      bit a;
      int tries;
      tries = 0;
      a = 0;
      while (!a && tries < 20) begin
         step(1, d, rdy, 0, a);
         tries++;
      end
      if (!a) chk("push_timeout", 0, 1);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1; instr_valid = 0; flush = 0; cmd_ready = 1;
      @(negedge clk); #1;
      chk("rst_instr_ready", int'(instr_ready), 0);
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("rst_cmd_valid",     int'(cmd_valid),     0);
      chk("rst_cmd_op",        int'(cmd_op),        0);
      chk("rst_cmd_regs",      int'({cmd_rd, cmd_rs1, cmd_rs2}), 0);
      chk("rst_cmd_addr",      int'(cmd_addr),      0);
      chk("rst_queue_count",   int'(queue_count),   0);
      chk("rst_illegal_count", int'(illegal_count), 0);
      chk("rst_illegal_pulse", int'(illegal_pulse), 0);
      chk("rst_instr_ready2",  int'(instr_ready),   0);
      exp_q.delete(); m_ill = 0; m_pulse = 0;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk); #1;
      chk("post_rst_instr_ready", int'(instr_ready), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a;
      do_reset();

      // Single MADD (addr must be forced to 0), then MLOAD with junk rs1/rs2.
      push(mk(4, 1, 2, 3, 'h55), 1);
      idle(2, 1);
      push(mk(1, 5, 7, 9, 'h1A3), 1);
      idle(2, 1);

      // Fill to full with the executor stalled, then stream 6 more.
      for (int i = 0; i < 4; i++) push(mk(3 + i % 3, i, i + 1, 7 - i, i), 0);
      idle(2, 0);
      step(1, mk(6, 2, 3, 0, 0), 0, 0, a);
      for (int i = 0; i < 6; i++) push(mk(1 + i % 6, i % 8, (i + 3) % 8, (i + 5) % 8, 100 + i), 1);
      idle(6, 1);

      // Illegal words: undefined opcodes and an out-of-range rs2.
      push(mk(0, 1, 1, 1, 0), 1);
      push(mk(7, 1, 1, 1, 0), 1);
      push(mk(3, 1, 1, 8, 0), 1);
      idle(2, 1);
      for (int i = 0; i < 300; i++) push(mk(($urandom_range(0, 1) != 0) ? 7 : 0, 0, 0, 0, i), 1);
      idle(1, 1);
      chk("illegal_saturated", int'(illegal_count), 255);

      // Flush with three queued and a simultaneous valid word.
      for (int i = 0; i < 3; i++) push(mk(2, 0, i, 0, 7 * i), 0);
      step(1, mk(4, 1, 1, 1, 0), 1, 1, a);
      idle(2, 1);

      // Simultaneous push and pop with two queued, then reset mid-operation.
      for (int i = 0; i < 2; i++) push(mk(5, i, i, i, 0), 0);
      step(1, mk(5, 3, 3, 3, 0), 1, 0, a);
      step(0, 32'h0, 0, 0, a);
      do_reset();

      // Randomized traffic.
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, rnd_word(), $urandom_range(0, 2) != 0,
              $urandom_range(0, 40) == 0, a);
      idle(8, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/matrix_cmd_decoder.md
Name: matrix_cmd_decoder

Overview:
- Front-end stage directly upstream of the matrix execution unit.
- Accepts 32-bit matrix ISA instruction words over a valid/ready stream and decodes them into matrix_op_t commands with register and address fields.
- Buffers decoded commands in a FIFO and presents them to the executor over a second valid/ready stream.
- Drops illegal instructions and counts them.

Parameters:
- FIFO_DEPTH, 4, number of decoded-command entries; power of two, at least 2.
- NUM_MREGS, 8, number of architectural matrix registers; indices at or above this value are illegal.
- ADDR_W, 14, width of the address/immediate field.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all queued commands; synchronous.
- instr_valid  in  1  upstream instruction valid.
- instr_ready  out  1  decoder can accept an instruction.
- instr_data  in  32  instruction word: [31:29] opcode, [28:24] rd, [23:19] rs1, [18:14] rs2, [13:0] addr.
- cmd_valid  out  1  decoded command at FIFO head.
- cmd_ready  in  1  executor accepts the head command.
- cmd_op  out  3  matrix_op_t of the head command.
- cmd_rd, cmd_rs1, cmd_rs2  out  5 each  register indices.
- cmd_addr  out  ADDR_W  address field.
- queue_count  out  $clog2(FIFO_DEPTH)+1  entries currently held.
- illegal_count  out  8  saturating count of dropped instructions.
- illegal_pulse  out  1  one-cycle pulse when an instruction is dropped.

Behaviour:
- Reset values: all outputs 0; cmd_op = MATRIX_NONE; instr_ready = 0 during rst and 1 in the first cycle after.
- Handshakes:
  - Input transfer: instr_valid && instr_ready.
  - Output transfer: cmd_valid && cmd_ready.
  - cmd_valid = (count != 0).
  - While cmd_valid is high, cmd_* fields are stable until popped.
- instr_ready = !full && !flush. Ready never depends on instr_valid. There is no same-cycle bypass when full.
- Latency: a legal instruction accepted in cycle N appears at cmd_* with cmd_valid high in cycle N+1 if the FIFO was empty. The FIFO is fully registered.
- Decode rules:
  - Opcode 0 (MATRIX_NONE) and 7 (undefined) are illegal.
  - Register indices checked against NUM_MREGS:
    - LOAD: rd only; rs1 and rs2 forced to 0 in the output.
    - STORE: rs1 only; rd and rs2 forced to 0.
    - MULTIPLY, ADD, SUBTRACT: rd, rs1 and rs2 all checked.
    - TRANSPOSE: rd and rs1 checked; rs2 forced to 0.
  - cmd_addr is passed through for LOAD and STORE and forced to 0 for all other ops.
- Illegal instruction:
  - Consumes the input handshake but is not written to the FIFO.
  - illegal_pulse is high the next cycle.
  - illegal_count increments and saturates at 255.
- Push and pop in the same cycle: count is unchanged and data ordering is preserved. When empty, a pop is impossible (cmd_valid = 0).
- Wrap-around: read and write pointers wrap modulo FIFO_DEPTH. Full/empty are derived from the count, not from pointer equality.
- flush:
  - Next cycle: count = 0, pointers = 0, cmd_valid = 0.
  - A pop handshake in the flush cycle is still honoured by the executor but has no additional effect on state.
  - illegal_count is not cleared by flush.
- rst mid-operation: same effect as flush, plus illegal_count cleared and illegal_pulse cleared.
- rst has priority over flush. flush has priority over push and pop.

Test Plan:
- After rst, push MADD rd=1 rs1=2 rs2=3 with cmd_ready=1 -> next cycle cmd_valid=1, cmd_op=4, rd=1/rs1=2/rs2=3, addr=0; popped; queue_count returns to 0.
- Push MLOAD rd=5 addr=0x1A3 with rs2 field=9 in the raw word -> cmd_op=1, rd=5, rs1=0, rs2=0, addr=0x1A3.
- Push 4 legal instructions with cmd_ready=0 -> queue_count=4, instr_ready=0. Then hold cmd_ready=1 and keep pushing 6 more -> all 10 emerge in order across pointer wrap, with no loss or duplication.
- Push opcode 0, opcode 7, and MMULT rs2=8 (NUM_MREGS=8) -> three illegal_pulse cycles, illegal_count=3, queue_count stays 0, cmd_valid never asserts. Then drive 300 illegal words -> illegal_count saturates at 255.
- Fill 3 entries, assert flush for one cycle alongside instr_valid=1 -> instr_ready=0 that cycle, next cycle queue_count=0 and cmd_valid=0, illegal_count unchanged.
- With 2 entries queued, push and pop in the same cycle -> queue_count stays 2 and head advances to the next entry. Then assert rst -> all outputs 0 the next cycle.
